// File: rtl/i2c_slave_regs_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regs_if
// Description : Pad-side I2C lines and fabric register-file access port of
//               the I2C register target.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_slave_regs_if #(
   parameter int REG_AW = 3
);
   logic              scl_pad_i;
   logic              sda_pad_i;
   logic              sda_pad_o;
   logic              sda_padoen_o;
   logic [REG_AW-1:0] reg_rd_addr_i;
   logic [7:0]        reg_rd_dat_o;
   logic              reg_wr_o;
   logic [REG_AW-1:0] reg_wr_addr_o;
   logic [7:0]        reg_wr_dat_o;
   logic              busy_o;

   // The I2C target itself
   modport slave (
      input  scl_pad_i, sda_pad_i, reg_rd_addr_i,
      output sda_pad_o, sda_padoen_o, reg_rd_dat_o,
             reg_wr_o, reg_wr_addr_o, reg_wr_dat_o, busy_o
   );

   // Pads plus fabric logic surrounding the target
   modport master (
      output scl_pad_i, sda_pad_i, reg_rd_addr_i,
      input  sda_pad_o, sda_padoen_o, reg_rd_dat_o,
             reg_wr_o, reg_wr_addr_o, reg_wr_dat_o, busy_o
   );
endinterface
`default_nettype wire

// File: rtl/i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_regs
// Description : I2C target with 7-bit address match, auto-incrementing
//               register pointer and a byte register file visible to fabric
//               logic through a combinational read port and a write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h42,
   parameter int         REG_AW   = 3
) (
   input wire                wb_clk_i,
   input wire                arst_i,
   i2c_slave_regs_if.slave   bus
);

   localparam int                c_DEPTH   = 2 ** REG_AW;
   localparam logic [REG_AW-1:0] c_PTR_ONE = REG_AW'(1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_ADDR     = 3'd1,
      S_ADDR_ACK = 3'd2,
      S_PTR      = 3'd3,
      S_WR_DATA  = 3'd4,
      S_RD_DATA  = 3'd5,
      S_RD_ACK   = 3'd6
   } state_t;

   state_t            r_state;
   logic              r_scl_s1, r_scl_s2, r_scl_d;
   logic              r_sda_s1, r_sda_s2, r_sda_d;
   logic [7:0]        r_shift;
   logic [3:0]        r_bit_cnt;
   logic [REG_AW-1:0] r_ptr;
   logic              r_rw;
   logic              r_mack;
   logic              r_padoen;
   logic              r_busy;
   logic              r_wr;
   logic [REG_AW-1:0] r_wr_addr;
   logic [7:0]        r_wr_dat;
   logic [7:0]        r_regs [c_DEPTH];

   logic              w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [REG_AW-1:0] w_ptr_inc;
   logic [7:0]        w_rd_byte, w_rd_next;

   // Edge and bus-condition detection on synchronised pad values
   assign w_scl_rise = r_scl_s2 & ~r_scl_d;
   assign w_scl_fall = ~r_scl_s2 & r_scl_d;
   assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
   assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;

   assign w_ptr_inc  = r_ptr + c_PTR_ONE;
   assign w_rd_byte  = r_regs[r_ptr];
   assign w_rd_next  = r_regs[w_ptr_inc];

   // Two-stage synchroniser plus history stage for edge detection; idle bus is high
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_scl_s1 <= 1'b1;
         r_scl_s2 <= 1'b1;
         r_scl_d  <= 1'b1;
         r_sda_s1 <= 1'b1;
         r_sda_s2 <= 1'b1;
         r_sda_d  <= 1'b1;
      end else begin
         r_scl_s1 <= bus.scl_pad_i;
         r_scl_s2 <= r_scl_s1;
         r_scl_d  <= r_scl_s2;
         r_sda_s1 <= bus.sda_pad_i;
         r_sda_s2 <= r_sda_s1;
         r_sda_d  <= r_sda_s2;
      end
   end

   // Protocol FSM: bits sampled on SCL rise, SDA driven/released on SCL fall.
   // r_bit_cnt counts received bits; 8 = byte complete, 9 = in our ACK slot.
   always_ff @(posedge wb_clk_i or negedge arst_i) begin
      if (!arst_i) begin
         r_state   <= S_IDLE;
         r_shift   <= 8'h00;
         r_bit_cnt <= 4'd0;
         r_ptr     <= '0;
         r_rw      <= 1'b0;
         r_mack    <= 1'b1;
         r_padoen  <= 1'b1;
         r_busy    <= 1'b0;
         r_wr      <= 1'b0;
         r_wr_addr <= '0;
         r_wr_dat  <= 8'h00;
         for (int i = 0; i < c_DEPTH; i++) begin
            r_regs[i] <= 8'h00;
         end
      end else begin
         r_wr <= 1'b0;
         if (w_start) begin
            // Also covers repeated START; the pointer is intentionally kept
            r_state   <= S_ADDR;
            r_bit_cnt <= 4'd0;
            r_padoen  <= 1'b1;
            r_busy    <= 1'b0;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_bit_cnt <= 4'd0;
            r_padoen  <= 1'b1;
            r_busy    <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR: begin
                  if (w_scl_rise && r_bit_cnt < 4'd8) begin
                     r_shift   <= {r_shift[6:0], r_sda_s2};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     if (r_shift[7:1] == DEV_ADDR) begin
                        r_padoen <= 1'b0;
                        r_busy   <= 1'b1;
                        r_rw     <= r_shift[0];
                        r_state  <= S_ADDR_ACK;
                     end else begin
                        r_state  <= S_IDLE;
                     end
                  end
               end
               S_ADDR_ACK: begin
                  if (w_scl_fall) begin
                     if (!r_rw) begin
                        r_padoen  <= 1'b1;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_PTR;
                     end else begin
                        // First read byte: MSB goes out on this same fall
                        r_shift   <= w_rd_byte;
                        r_padoen  <= w_rd_byte[7];
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_RD_DATA;
                     end
                  end
               end
               S_PTR, S_WR_DATA: begin
                  if (w_scl_rise && r_bit_cnt < 4'd8) begin
                     r_shift   <= {r_shift[6:0], r_sda_s2};
                     r_bit_cnt <= r_bit_cnt + 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
                     r_padoen  <= 1'b0;
                     r_bit_cnt <= 4'd9;
                     if (r_state == S_PTR) begin
                        r_ptr <= r_shift[REG_AW-1:0];
                     end else begin
                        r_regs[r_ptr] <= r_shift;
                        r_wr          <= 1'b1;
                        r_wr_addr     <= r_ptr;
                        r_wr_dat      <= r_shift;
                        r_ptr         <= w_ptr_inc;
                     end
                  end else if (w_scl_fall && r_bit_cnt == 4'd9) begin
                     r_padoen  <= 1'b1;
                     r_bit_cnt <= 4'd0;
                     r_state   <= S_WR_DATA;
                  end
               end
               S_RD_DATA: begin
                  if (w_scl_fall) begin
                     if (r_bit_cnt < 4'd8) begin
                        r_padoen  <= r_shift[6];
                        r_shift   <= {r_shift[6:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                     end else begin
                        r_padoen  <= 1'b1;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_RD_ACK;
                     end
                  end
               end
               S_RD_ACK: begin
                  if (w_scl_rise) begin
                     r_mack    <= r_sda_s2;
                     r_bit_cnt <= 4'd1;
                  end else if (w_scl_fall && r_bit_cnt == 4'd1) begin
                     if (!r_mack) begin
                        r_ptr     <= w_ptr_inc;
                        r_shift   <= w_rd_next;
                        r_padoen  <= w_rd_next[7];
                        r_bit_cnt <= 4'd1;
                        r_state   <= S_RD_DATA;
                     end else begin
                        // Master NACK: stay off the bus until STOP/START
                        r_padoen  <= 1'b1;
                        r_bit_cnt <= 4'd0;
                        r_state   <= S_IDLE;
                     end
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign bus.sda_pad_o     = 1'b0;
   assign bus.sda_padoen_o  = r_padoen;
   assign bus.busy_o        = r_busy;
   assign bus.reg_wr_o      = r_wr;
   assign bus.reg_wr_addr_o = r_wr_addr;
   assign bus.reg_wr_dat_o  = r_wr_dat;
   assign bus.reg_rd_dat_o  = r_regs[bus.reg_rd_addr_i];

endmodule
`default_nettype wire

// File: tb/tb_i2c_slave_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_slave_regs
// Description : Bit-banged I2C host driving i2c_slave_regs, checked against a
//               transaction-level register/pointer model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2c_slave_regs;

   localparam int REG_AW = 3;
   localparam int DEPTH  = 8;
   localparam int Q      = 10;   // system clocks per quarter SCL period

   logic              clk     = 1'b0;
   logic              arst_n  = 1'b0;
   logic              scl     = 1'b1;
   logic              m_sda   = 1'b1;
   logic [REG_AW-1:0] rd_addr = '0;
   bit                chk_en  = 1'b0;

   int                total = 0;
   int                bad   = 0;

   // Reference model: register contents, pointer, expected write strobes
   logic [7:0]        m_regs [DEPTH];
   int                m_ptr;
   logic [10:0]       exp_q [$];
   logic [10:0]       exp_item;

   always #5 clk = ~clk;

   i2c_slave_regs_if #(.REG_AW(REG_AW)) bus ();

   // Open-drain wire-AND of host and target
   assign bus.scl_pad_i     = scl;
   assign bus.sda_pad_i     = m_sda & bus.sda_padoen_o;
   assign bus.reg_rd_addr_i = rd_addr;

   i2c_slave_regs #(.DEV_ADDR(7'h42), .REG_AW(REG_AW)) dut (
      .wb_clk_i (clk),
      .arst_i   (arst_n),
      .bus      (bus.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every write strobe must match the next expected commit; idle checks when enabled
   always @(negedge clk) begin
      if (bus.reg_wr_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", bus.reg_wr_o, 1'b0);
         end else begin
            exp_item = exp_q.pop_front();
            check("wr_addr", bus.reg_wr_addr_o, exp_item[10:8]);
            check("wr_dat", bus.reg_wr_dat_o, exp_item[7:0]);
         end
      end
      if (chk_en) begin
         check("idle_rd_dat", bus.reg_rd_dat_o, m_regs[rd_addr]);
         check("idle_busy", bus.busy_o, 1'b0);
         check("idle_sda", bus.sda_padoen_o, 1'b1);
      end
   end

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_regs[i] = 8'h00;
      m_ptr = 0;
   endtask

   task automatic i2c_start();
      m_sda = 1'b1; wait_q(1);
      scl   = 1'b1; wait_q(1);
      m_sda = 1'b0; wait_q(1);
      scl   = 1'b0; wait_q(1);
   endtask

   task automatic i2c_stop();
      m_sda = 1'b0; wait_q(1);
      scl   = 1'b1; wait_q(1);
      m_sda = 1'b1; wait_q(2);
   endtask

   task automatic clk_bit(input logic b, output logic seen);
      m_sda = b;    wait_q(1);
      scl   = 1'b1; wait_q(1);
      seen  = bus.sda_pad_i;
      wait_q(1);
      scl   = 1'b0; wait_q(1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
      logic s;
      for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
      clk_bit(1'b1, s);
      check(name, s, exp_ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] b);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         clk_bit(1'b1, s);
         b[i] = s;
      end
      clk_bit(mack, s);
   endtask

   task automatic wr_ptr(input logic [7:0] p);
      m_ptr = int'(p) % DEPTH;
      send_byte(p, 1'b0, "ack_ptr");
   endtask

   task automatic wr_data(input logic [7:0] d);
      exp_q.push_back({3'(m_ptr), d});
      m_regs[m_ptr] = d;
      m_ptr = (m_ptr + 1) % DEPTH;
      send_byte(d, 1'b0, "ack_data");
   endtask

   task automatic rd_data(input logic mack, input logic [7:0] lit);
      logic [7:0] b;
      logic [7:0] e;
      e = m_regs[m_ptr];
      recv_byte(mack, b);
      check("rd_model", b, e);
      check("rd_literal", b, lit);
      if (!mack) m_ptr = (m_ptr + 1) % DEPTH;
   endtask

   task automatic lit_reg(input int a, input logic [7:0] v);
      rd_addr = 3'(a);
      #1;
      check("reg_literal", bus.reg_rd_dat_o, v);
   endtask

   task automatic idle_sweep(input int n);
      chk_en = 1'b1;
      repeat (n) begin
         @(posedge clk);
         #1 rd_addr = rd_addr + 3'd1;
      end
      @(negedge clk);
      chk_en = 1'b0;
   endtask

   initial begin
      logic [7:0] dummy;
      model_reset();

      // Reset with SDA held low by the host
      arst_n = 1'b0;
      m_sda  = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_sda", bus.sda_padoen_o, 1'b1);
      check("rst_busy", bus.busy_o, 1'b0);
      check("rst_wr", bus.reg_wr_o, 1'b0);
      for (int a = 0; a < DEPTH; a++) lit_reg(a, 8'h00);
      m_sda = 1'b1;
      @(negedge clk);
      arst_n = 1'b1;
      wait_q(2);

      // Pointer 3, two data bytes
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      check("busy_match", bus.busy_o, 1'b1);
      wr_ptr(8'h03);
      wr_data(8'hA5);
      wr_data(8'h5A);
      i2c_stop();
      check("busy_stop", bus.busy_o, 1'b0);
      check("pending_wr_1", exp_q.size(), 0);
      lit_reg(3, 8'hA5);
      lit_reg(4, 8'h5A);
      idle_sweep(16);

      // Wrong address: no ACK, stays idle
      i2c_start();
      send_byte(8'h86, 1'b1, "nack_addr");
      check("nomatch_busy", bus.busy_o, 1'b0);
      check("nomatch_sda", bus.sda_padoen_o, 1'b1);
      i2c_stop();
      idle_sweep(16);

      // Pointer wrap from 7 to 0
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      wr_ptr(8'h07);
      wr_data(8'h11);
      wr_data(8'h22);
      i2c_stop();
      lit_reg(7, 8'h11);
      lit_reg(0, 8'h22);
      idle_sweep(16);

      // Preload 6,7,0 then combined write-pointer / repeated-START read
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      wr_ptr(8'h06);
      wr_data(8'hC3);
      wr_data(8'h3C);
      wr_data(8'h99);
      i2c_stop();
      idle_sweep(16);
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      wr_ptr(8'h06);
      i2c_start();
      send_byte(8'h85, 1'b0, "ack_addr_r");
      rd_data(1'b0, 8'hC3);
      rd_data(1'b0, 8'h3C);
      rd_data(1'b1, 8'h99);
      check("rel_after_nack", bus.sda_padoen_o, 1'b1);
      i2c_stop();
      idle_sweep(16);

      // Partial data byte aborted by STOP
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      wr_ptr(8'h02);
      for (int i = 0; i < 5; i++) clk_bit(1'b1, dummy[0]);
      i2c_stop();
      check("abort_busy", bus.busy_o, 1'b0);
      lit_reg(2, 8'h00);
      idle_sweep(16);

      // Reset while the target drives a 0 read bit
      i2c_start();
      send_byte(8'h84, 1'b0, "ack_addr_w");
      wr_ptr(8'h02);
      i2c_start();
      send_byte(8'h85, 1'b0, "ack_addr_r");
      check("rd_drive0", bus.sda_padoen_o, 1'b0);
      arst_n = 1'b0;
      #1;
      check("rst_mid_read", bus.sda_padoen_o, 1'b1);
      check("rst_mid_busy", bus.busy_o, 1'b0);
      model_reset();
      @(negedge clk);
      arst_n = 1'b1;
      scl    = 1'b1;
      m_sda  = 1'b1;
      wait_q(2);
      lit_reg(3, 8'h00);
      lit_reg(6, 8'h00);
      idle_sweep(16);

      check("pending_wr_end", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_slave_regs.md
Name: i2c_slave_regs

Overview:
- I2C target (responder) at the opposite end of the bus from the team's I2C master core.
- Decodes START/STOP, matches a 7-bit device address and ACKs it.
- Supports a register pointer with auto-increment over an internal byte register file.
- Exposes the register file to fabric logic through a read port and a write-notification strobe, so FPGA-side control blocks can be configured from an external I2C host.

Parameters:
DEV_ADDR, 7'h42, 7-bit I2C device address matched after START
REG_AW, 3, register-file address width; depth = 2**REG_AW bytes

Ports:
wb_clk_i  in  1  system clock; must be ≥ 16× SCL frequency
arst_i  in  1  asynchronous reset, active-low
scl_pad_i  in  1  SCL input from pad
sda_pad_i  in  1  SDA input from pad
sda_pad_o  out  1  SDA output value, tied 0 (open-drain)
sda_padoen_o  out  1  SDA output enable, active-low; 1 = released
reg_rd_addr_i  in  REG_AW  fabric read address
reg_rd_dat_o  out  8  combinational read data of reg_rd_addr_i
reg_wr_o  out  1  one-cycle pulse when an I2C write commits a byte
reg_wr_addr_o  out  REG_AW  address of committed byte, valid with reg_wr_o
reg_wr_dat_o  out  8  data of committed byte, valid with reg_wr_o
busy_o  out  1  high from address match until STOP or next START

Behaviour:
- Reset (arst_i=0, asynchronous):
  - sda_padoen_o=1, reg_wr_o=0, reg_wr_addr_o=0, reg_wr_dat_o=0, busy_o=0.
  - Register file cleared to 8'h00; pointer=0; state IDLE.
- Input synchronisation:
  - scl/sda each pass through a 2-FF synchroniser plus one history FF.
  - Edges are detected on synchronised values, so 2-cycle input latency.
- Bus conditions:
  - START = sda falling while scl high.
  - STOP = sda rising while scl high.
  - Both are detected in any state.
  - START (including repeated START): enter ADDR with bit counter=0 and sda released.
  - STOP: enter IDLE, release sda, busy_o=0.
- Bit timing:
  - Received bits are sampled on scl rising.
  - sda_padoen_o changes only on scl falling (one cycle after edge detection).
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first. On the 8th falling edge:
    - If [7:1]==DEV_ADDR: drive ACK (padoen=0), set busy_o, go to ADDR_ACK.
    - Otherwise: go to IDLE, sda released, no ACK.
  - ADDR_ACK: on the next falling edge, release sda.
    - If R/W=0: go to PTR.
    - If R/W=1: load the shift register from regfile[pointer], drive its MSB, go to RD_DATA.
  - PTR: receive 8 bits, ACK, pointer <= byte[REG_AW-1:0]; upper bits ignored. Then go to WR_DATA.
  - WR_DATA: receive 8 bits, ACK. On the 8th falling edge:
    - Write regfile[pointer].
    - Pulse reg_wr_o for exactly 1 cycle with the pointer and data.
    - pointer <= pointer+1, wrapping modulo 2**REG_AW.
    - Stay in WR_DATA for further bytes.
  - RD_DATA: shift out 8 bits; each bit is driven on scl falling (bit 0 drives low → padoen=0; bit 1 → released). After the 8th bit, release sda and go to RD_ACK.
  - RD_ACK: sample master ACK on scl rising.
    - ACK (0): pointer+1 with wrap; load next byte; drive MSB on falling; go to RD_DATA.
    - NACK (1): go to IDLE (wait for STOP/START), sda released.
- Read data is fetched at byte load time. A write to the same address in the same cycle returns the old value.
- Repeated START after a pointer write preserves the pointer (combined write-then-read transaction).
- STOP/START arriving mid-byte aborts the partial byte with no write and no pulse.
- Reset mid-transfer releases sda immediately.
- reg_rd_dat_o = regfile[reg_rd_addr_i], combinational, with no effect on I2C state.

Test Plan:
- Reset with sda_pad_i=0 held → sda_padoen_o=1, busy_o=0, all reg_rd_dat_o=00 across addresses 0..7.
- START, 0x84 (0x42 write), 0x03, 0xA5, 0x5A, STOP → ACK on all 4 bytes; reg_wr_o pulses twice, with (3,A5) then (4,5A); reg_rd_dat_o[3]=A5, [4]=5A; busy_o low after STOP.
- START, 0x86 → no ACK (sda released in 9th clock), state IDLE, no reg_wr_o.
- Write ptr 0x07, then data 0x11, 0x22 → regs 7=11, 0=22 (wrap).
- Preload regs 6=C3, 7=3C, 0=99. Then: START, 0x84, 0x06, repeated START, 0x85, read 3 bytes (ACK, ACK, NACK), STOP → SDA returns C3, 3C, 99; sda released after NACK.
- Write ptr 0x02, send 5 data bits, then STOP → no reg_wr_o and reg 2 unchanged. Then assert arst_i mid-read bit 0 → sda_padoen_o=1 immediately.
